// File: rtl/aa_sched_pkg.sv
// Shared defaults and FSM state encoding for the range-write scheduler.
package aa_sched_pkg;

    localparam int DEPTH_DEF = 16;
    localparam int WIDTH_DEF = 8;
    localparam int AW_DEF    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        ACK   = 2'd2
    } sched_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves only when a grant is accepted.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic accept,
    output logic grant_a,
    output logic grant_b
);

    // prio_b low means A wins a tie; it flips to the loser of each accepted grant.
    logic prio_b;

    assign grant_a = req_a && (!req_b || !prio_b);
    assign grant_b = req_b && (!req_a || prio_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_b <= 1'b0;
        end else if (accept && (grant_a || grant_b)) begin
            prio_b <= grant_a;
        end
    end

endmodule

// File: rtl/aa_write_scheduler.sv
// Schedules range writes from two requesters into a single-write-port array,
// one row per cycle, with a registered read port.
module aa_write_scheduler
    import aa_sched_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_a,
    input  logic [AW-1:0]      lo_a,
    input  logic [AW-1:0]      hi_a,
    input  logic [WIDTH-1:0]   data_a,
    input  logic               req_b,
    input  logic [AW-1:0]      lo_b,
    input  logic [AW-1:0]      hi_b,
    input  logic [WIDTH-1:0]   data_b,
    output logic               grant_a,
    output logic               grant_b,
    output logic               ack_a,
    output logic               ack_b,
    output logic               busy,
    input  logic [AW-1:0]      rd_addr,
    output logic [WIDTH-1:0]   rd_data,
    output sched_state_t       state
);

    localparam logic [AW-1:0] LAST_ROW = AW'(DEPTH - 1);

    logic               arb_a;
    logic               arb_b;
    logic               accept;
    logic               owner_b;
    logic               sweep_done;
    logic [AW-1:0]      cnt;
    logic [AW-1:0]      hi_q;
    logic [WIDTH-1:0]   data_q;
    logic [WIDTH-1:0]   mem [DEPTH];

    // Handshake: req is held until its ack pulse; req and the range fields
    // are sampled only while IDLE, so nothing the requester does mid-sweep matters.
    assign accept = (state == IDLE) && (req_a || req_b);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_a   (req_a),
        .req_b   (req_b),
        .accept  (accept),
        .grant_a (arb_a),
        .grant_b (arb_b)
    );

    // lo > hi ends after the first row; the clamp keeps the counter inside the array.
    assign sweep_done = (cnt >= hi_q) || (cnt >= LAST_ROW);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant_a <= 1'b0;
            grant_b <= 1'b0;
            ack_a   <= 1'b0;
            ack_b   <= 1'b0;
            busy    <= 1'b0;
            owner_b <= 1'b0;
            cnt     <= '0;
            hi_q    <= '0;
            data_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner_b <= arb_b;
                        cnt     <= arb_b ? lo_b : lo_a;
                        hi_q    <= arb_b ? hi_b : hi_a;
                        data_q  <= arb_b ? data_b : data_a;
                        grant_a <= arb_a;
                        grant_b <= arb_b;
                        busy    <= 1'b1;
                        state   <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (sweep_done) begin
                        grant_a <= 1'b0;
                        grant_b <= 1'b0;
                        ack_a   <= !owner_b;
                        ack_b   <= owner_b;
                        state   <= ACK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACK: begin
                    ack_a <= 1'b0;
                    ack_b <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    grant_a <= 1'b0;
                    grant_b <= 1'b0;
                    ack_a   <= 1'b0;
                    ack_b   <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // The only write port of the array; reads see the pre-write value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            rd_data <= (int'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;
            if (state == SWEEP && int'(cnt) < DEPTH) begin
                mem[cnt] <= data_q;
            end
        end
    end

endmodule
